// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through a single 4-bit ripple adder.
// Optional: define NIBBLE_ADD_OVF_EN to add the registered signed-overflow output ovf.

module RippleCarryAdder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[4];

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry_reg;
    logic [CW-1:0]    cnt;

    logic [3:0] add_sum;
    logic       add_co;
    logic       load;
    logic       step;
    logic       last;

    RippleCarryAdder_4bit u_add (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (carry_reg),
        .sum   (add_sum),
        .c_out (add_co)
    );

    assign load = (state == IDLE) && start;
    assign step = (state == RUN);
    assign last = (cnt == CW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Result nibbles enter from the top so the last one lands in sum[WIDTH-1:WIDTH-4].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else begin
            unique case (1'b1)
                load: begin
                    a_sh      <= in1;
                    b_sh      <= in2;
                    carry_reg <= c_in;
                    cnt       <= '0;
                end
                step: begin
                    a_sh      <= a_sh >> 4;
                    b_sh      <= b_sh >> 4;
                    res_sh    <= WIDTH'({add_sum, res_sh} >> 4);
                    carry_reg <= add_co;
                    cnt       <= cnt + 1'b1;
                    if (last) begin
                        sum   <= WIDTH'({add_sum, res_sh} >> 4);
                        c_out <= add_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef NIBBLE_ADD_OVF_EN
    // Signed overflow needs only the sign bits of the final nibble pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (step && last) begin
            ovf <= (a_sh[3] & b_sh[3] & ~add_sum[3])
                 | (~a_sh[3] & ~b_sh[3] & add_sum[3]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder against an arithmetic model.
// Define NIBBLE_ADD_OVF_EN for both files to cover the ovf output.

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef NIBBLE_ADD_OVF_EN
    logic             ovf;
    logic             exp_ovf;
`endif

    int checks;
    int failures;

    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;

    nibble_serial_adder #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef NIBBLE_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned (WIDTH+1)-bit sum and signed overflow from the sign bits.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ci);
        logic [WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        exp_sum  = t[WIDTH-1:0];
        exp_cout = t[WIDTH];
`ifdef NIBBLE_ADD_OVF_EN
        exp_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
`endif
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(c_out), 32'(exp_cout));
`ifdef NIBBLE_ADD_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // Called #1 after an edge with the DUT idle; returns likewise.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic ci);
        start = 1'b1;
        in1   = a;
        in2   = b;
        c_in  = ci;
        tick();
        start = 1'b0;
        in1   = WIDTH'($urandom);
        in2   = WIDTH'($urandom);
        c_in  = 1'($urandom);
        for (int i = 0; i < NIB; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check_result({tag, "_hold"});
            start = 1'($urandom);
            tick();
        end
        start = 1'b0;
        model(a, b, ci);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_dn"}, 32'(busy), 32'd0);
        check_result(tag);
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic held_start_test();
        logic [WIDTH-1:0] oa [2*NIB+4];
        logic [WIDTH-1:0] ob [2*NIB+4];
        logic             oc [2*NIB+4];
        int               acc;
        bit               exp_busy;
        bit               exp_done;
        start = 1'b1;
        for (int c = 0; c <= 2*NIB + 3; c++) begin
            oa[c] = WIDTH'($urandom);
            ob[c] = WIDTH'($urandom);
            oc[c] = 1'($urandom);
            in1   = oa[c];
            in2   = ob[c];
            c_in  = oc[c];
            // Operations are accepted every NIB+2 cycles, at cycles 0 and NIB+2.
            acc      = (c >= NIB + 2) ? NIB + 2 : 0;
            exp_busy = (c - acc >= 1) && (c - acc <= NIB);
            exp_done = (c - acc == NIB + 1);
            check("held_busy", 32'(busy), 32'(exp_busy));
            check("held_done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                model(oa[acc], ob[acc], oc[acc]);
                check_result("held");
            end
            tick();
        end
        start = 1'b0;
        tick();
        check("held_end_busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_test();
        run_op("pre_rst", 16'h1234, 16'h4321, 1'b0);
        start = 1'b1;
        in1   = 16'hAAAA;
        in2   = 16'h1111;
        c_in  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
        exp_ovf = 1'b0;
`endif
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_result("rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            tick();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        check_result("post_rst");
        run_op("after_rst", 16'h00FF, 16'h0F01, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in1      = '0;
        in2      = '0;
        c_in     = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
        exp_ovf = 1'b0;
`endif
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check_result("reset");
        rst_n = 1'b1;
        tick();
        tick();

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        run_op("carry_all", 16'hFFFF, 16'h0001, 1'b0);
        run_op("cin_carry", 16'hFFFF, 16'h0000, 1'b1);
        run_op("zero", 16'h0000, 16'h0000, 1'b0);
        run_op("max_all", 16'hFFFF, 16'hFFFF, 1'b1);
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
        run_op("neg_ovf", 16'h8000, 16'h8000, 1'b0);

        held_start_test();
        reset_test();

        for (int i = 0; i < 25; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
